// File: rtl/alu_writeback.sv
// Writeback stage behind the ALU: S1 capture, destination decode, bypassed 32x32 register file,
// branch reporting, sticky status and overflow count. Optional overflow trap: ALU_WB_OVF_TRAP_EN.
module alu_writeback #(
    parameter int REG_COUNT = 32,
    parameter int OVF_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [31:0]          i_inst_code,
    input  logic [31:0]          i_alu_res,
    input  logic [2:0]           i_alu_flag,
    input  logic [4:0]           i_rd_addr_a,
    output logic [31:0]          o_rd_data_a,
    input  logic [4:0]           i_rd_addr_b,
    output logic [31:0]          o_rd_data_b,
    output logic                 o_wb_valid,
    output logic [4:0]           o_wb_addr,
    output logic [31:0]          o_wb_data,
    output logic                 o_br_taken,
    output logic [15:0]          o_br_offset,
    output logic [2:0]           o_sticky_flags,
    input  logic                 i_sticky_clr,
    output logic [OVF_CNT_W-1:0] o_ovf_count
`ifdef ALU_WB_OVF_TRAP_EN
    ,
    output logic                 o_trap,
    input  logic                 i_trap_ack
`endif
);

    logic                 r_s1_valid;
    logic [31:0]          r_s1_inst;
    logic [31:0]          r_s1_res;
    logic [2:0]           r_s1_flag;
    logic [31:0]          r_regs [REG_COUNT];
    logic [15:0]          r_br_offset;
    logic [2:0]           r_sticky;
    logic [OVF_CNT_W-1:0] r_ovf_count;

    logic                 w_accept;
    logic [5:0]           w_opcode;
    logic [5:0]           w_func;
    logic                 w_writes;
    logic [4:0]           w_dest;
    logic                 w_is_branch;
    logic                 w_is_arith;
    logic                 w_ovf_block;
    logic                 w_commit;
    logic                 w_br_update;
    logic                 w_arith_update;
    logic                 w_unused_fields;

    assign w_accept        = i_in_valid & o_in_ready;
    assign w_opcode        = r_s1_inst[31:26];
    assign w_func          = r_s1_inst[5:0];
    assign w_unused_fields = ^{r_s1_inst[25:21], r_s1_inst[10:6]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_inst  <= '0;
            r_s1_res   <= '0;
            r_s1_flag  <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_inst <= i_inst_code;
                r_s1_res  <= i_alu_res;
                r_s1_flag <= i_alu_flag;
            end
        end
    end

    always_comb begin
        w_writes    = 1'b0;
        w_dest      = 5'd0;
        w_is_branch = 1'b0;
        w_is_arith  = 1'b0;
        case (w_opcode)
            6'b000000: begin
                w_dest = r_s1_inst[15:11];
                case (w_func)
                    6'b100000, 6'b100001, 6'b100010, 6'b100011,
                    6'b000000, 6'b000100, 6'b000010, 6'b000110,
                    6'b000011, 6'b000111, 6'b100100, 6'b100101,
                    6'b100110, 6'b100111, 6'b101010, 6'b101011: w_writes = 1'b1;
                    default:                                    w_writes = 1'b0;
                endcase
                w_is_arith = (w_func == 6'b100000) || (w_func == 6'b100010);
            end
            6'b001000, 6'b001001, 6'b001100, 6'b001101,
            6'b001110, 6'b001010, 6'b001011: begin
                w_dest     = r_s1_inst[20:16];
                w_writes   = 1'b1;
                w_is_arith = (w_opcode == 6'b001000);
            end
            6'b000100, 6'b000101: w_is_branch = 1'b1;
            default: begin
                w_writes = 1'b0;
            end
        endcase
    end

`ifdef ALU_WB_OVF_TRAP_EN
    assign w_ovf_block = w_is_arith & r_s1_flag[2];
`else
    assign w_ovf_block = 1'b0;
`endif

    // Writes to r0 never commit, so r_regs[0] stays zero from reset onward.
    assign w_commit   = r_s1_valid & w_writes & ~w_ovf_block & (w_dest != 5'd0);
    assign o_wb_valid = w_commit;
    assign o_wb_addr  = w_commit ? w_dest : 5'd0;
    assign o_wb_data  = w_commit ? r_s1_res : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            r_regs[w_dest] <= r_s1_res;
        end
    end

    assign o_rd_data_a = (i_rd_addr_a == 5'd0) ? 32'd0 :
                         (w_commit && (i_rd_addr_a == w_dest)) ? r_s1_res : r_regs[i_rd_addr_a];
    assign o_rd_data_b = (i_rd_addr_b == 5'd0) ? 32'd0 :
                         (w_commit && (i_rd_addr_b == w_dest)) ? r_s1_res : r_regs[i_rd_addr_b];

    assign w_br_update = r_s1_valid & w_is_branch;
    assign o_br_taken  = w_br_update & ~r_s1_flag[0];
    assign o_br_offset = w_br_update ? r_s1_res[15:0] : r_br_offset;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_offset <= '0;
        end else if (w_br_update) begin
            r_br_offset <= r_s1_res[15:0];
        end
    end

    // Status accounting follows the instruction even when a trap suppresses its write.
    assign w_arith_update = r_s1_valid & w_is_arith;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky    <= '0;
            r_ovf_count <= '0;
        end else if (i_sticky_clr) begin
            r_sticky    <= w_arith_update ? r_s1_flag : 3'b000;
            r_ovf_count <= (w_arith_update && r_s1_flag[2]) ? OVF_CNT_W'(1) : '0;
        end else if (w_arith_update) begin
            r_sticky <= r_sticky | r_s1_flag;
            if (r_s1_flag[2] && (r_ovf_count != {OVF_CNT_W{1'b1}})) begin
                r_ovf_count <= r_ovf_count + OVF_CNT_W'(1);
            end
        end
    end

    assign o_sticky_flags = r_sticky;
    assign o_ovf_count    = r_ovf_count;

`ifdef ALU_WB_OVF_TRAP_EN
    logic r_trap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trap <= 1'b0;
        end else if (r_s1_valid && w_ovf_block) begin
            r_trap <= 1'b1;
        end else if (r_trap && i_trap_ack) begin
            r_trap <= 1'b0;
        end
    end

    assign o_trap     = r_trap;
    assign o_in_ready = ~r_trap;
`else
    assign o_in_ready = 1'b1;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Directed self-checking bench for alu_writeback; trap scenario built with ALU_WB_OVF_TRAP_EN.
`timescale 1ns/1ps
module tb_alu_writeback;

    logic        clk;
    logic        rst_n;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [31:0] i_inst_code;
    logic [31:0] i_alu_res;
    logic [2:0]  i_alu_flag;
    logic [4:0]  i_rd_addr_a;
    logic [31:0] o_rd_data_a;
    logic [4:0]  i_rd_addr_b;
    logic [31:0] o_rd_data_b;
    logic        o_wb_valid;
    logic [4:0]  o_wb_addr;
    logic [31:0] o_wb_data;
    logic        o_br_taken;
    logic [15:0] o_br_offset;
    logic [2:0]  o_sticky_flags;
    logic        i_sticky_clr;
    logic [15:0] o_ovf_count;
`ifdef ALU_WB_OVF_TRAP_EN
    logic        o_trap;
    logic        i_trap_ack;
`endif

    int errors = 0;
    int checks = 0;

    alu_writeback #(.REG_COUNT(32), .OVF_CNT_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_in_valid     (i_in_valid),
        .o_in_ready     (o_in_ready),
        .i_inst_code    (i_inst_code),
        .i_alu_res      (i_alu_res),
        .i_alu_flag     (i_alu_flag),
        .i_rd_addr_a    (i_rd_addr_a),
        .o_rd_data_a    (o_rd_data_a),
        .i_rd_addr_b    (i_rd_addr_b),
        .o_rd_data_b    (o_rd_data_b),
        .o_wb_valid     (o_wb_valid),
        .o_wb_addr      (o_wb_addr),
        .o_wb_data      (o_wb_data),
        .o_br_taken     (o_br_taken),
        .o_br_offset    (o_br_offset),
        .o_sticky_flags (o_sticky_flags),
        .i_sticky_clr   (i_sticky_clr),
        .o_ovf_count    (o_ovf_count)
`ifdef ALU_WB_OVF_TRAP_EN
        ,
        .o_trap         (o_trap),
        .i_trap_ack     (i_trap_ack)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [5:0] func);
        return {6'b000000, 5'd0, 5'd0, rd, 5'd0, func};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt);
        return {op, 5'd0, rt, 16'h0000};
    endfunction

    task automatic set_in(input logic v, input logic [31:0] inst, input logic [31:0] res,
                          input logic [2:0] flag);
        i_in_valid  = v;
        i_inst_code = inst;
        i_alu_res   = res;
        i_alu_flag  = flag;
    endtask

    task automatic test_reset;
        checks++; if (o_in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", o_in_ready); end
        checks++; if (o_wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wbv: got %0b want 0", o_wb_valid); end
        checks++; if (o_wb_addr !== 5'd0 || o_wb_data !== 32'd0) begin errors++; $display("FAIL reset_wb: got %0d/%h want 0/0", o_wb_addr, o_wb_data); end
        checks++; if (o_br_taken !== 1'b0 || o_br_offset !== 16'd0) begin errors++; $display("FAIL reset_br: got %0b/%h want 0/0", o_br_taken, o_br_offset); end
        checks++; if (o_sticky_flags !== 3'd0 || o_ovf_count !== 16'd0) begin errors++; $display("FAIL reset_stat: got %b/%h want 000/0", o_sticky_flags, o_ovf_count); end
`ifdef ALU_WB_OVF_TRAP_EN
        checks++; if (o_trap !== 1'b0) begin errors++; $display("FAIL reset_trap: got %0b want 0", o_trap); end
`endif
        for (int a = 1; a < 32; a++) begin
            i_rd_addr_a = 5'(a);
            i_rd_addr_b = 5'(32 - a);
            #1;
            checks++; if (o_rd_data_a !== 32'd0 || o_rd_data_b !== 32'd0) begin errors++; $display("FAIL reset_regs r%0d: got %h/%h want 0/0", a, o_rd_data_a, o_rd_data_b); end
        end
    endtask

    task automatic test_write_bypass;
        set_in(1'b1, 32'h0001_1020, 32'h0000_0007, 3'b000);
        i_rd_addr_a = 5'd2;
        i_rd_addr_b = 5'd2;
        @(posedge clk); #1;
        set_in(1'b0, 32'd0, 32'd0, 3'b000);
        #1;
        checks++; if (o_wb_valid !== 1'b1 || o_wb_addr !== 5'd2 || o_wb_data !== 32'd7) begin errors++; $display("FAIL wb_commit: got %0b/%0d/%h want 1/2/7", o_wb_valid, o_wb_addr, o_wb_data); end
        checks++; if (o_rd_data_a !== 32'd7 || o_rd_data_b !== 32'd7) begin errors++; $display("FAIL bypass_r2: got %h/%h want 7/7", o_rd_data_a, o_rd_data_b); end
        @(posedge clk); #1;
        checks++; if (o_wb_valid !== 1'b0) begin errors++; $display("FAIL wb_idle: got %0b want 0", o_wb_valid); end
        checks++; if (o_rd_data_a !== 32'd7) begin errors++; $display("FAIL regfile_r2: got %h want 7", o_rd_data_a); end
    endtask

    task automatic test_reg0;
        set_in(1'b1, itype(6'b001101, 5'd0), 32'h0000_FFFF, 3'b000);
        i_rd_addr_a = 5'd0;
        @(posedge clk); #1;
        set_in(1'b0, 32'd0, 32'd0, 3'b000);
        #1;
        checks++; if (o_wb_valid !== 1'b0) begin errors++; $display("FAIL r0_wbv: got %0b want 0", o_wb_valid); end
        checks++; if (o_rd_data_a !== 32'd0) begin errors++; $display("FAIL r0_bypass: got %h want 0", o_rd_data_a); end
        @(posedge clk); #1;
        checks++; if (o_rd_data_a !== 32'd0) begin errors++; $display("FAIL r0_read: got %h want 0", o_rd_data_a); end
    endtask

    task automatic test_decode;
        logic [31:0] inst [6];
        logic        ev   [6];
        logic [4:0]  ea   [6];
        inst[0] = rtype(5'd8, 6'b001000);       ev[0] = 1'b0; ea[0] = 5'd0;
        inst[1] = itype(6'b100011, 5'd4);       ev[1] = 1'b0; ea[1] = 5'd0;
        inst[2] = itype(6'b101011, 5'd4);       ev[2] = 1'b0; ea[2] = 5'd0;
        inst[3] = itype(6'b000010, 5'd4);       ev[3] = 1'b0; ea[3] = 5'd0;
        inst[4] = itype(6'b001001, 5'd6);       ev[4] = 1'b1; ea[4] = 5'd6;
        inst[5] = rtype(5'd10, 6'b101011);      ev[5] = 1'b1; ea[5] = 5'd10;
        for (int i = 0; i < 6; i++) begin
            set_in(1'b1, inst[i], 32'hA0 + 32'(i), 3'b000);
            @(posedge clk); #1;
            set_in(1'b0, 32'd0, 32'd0, 3'b000);
            #1;
            checks++; if (o_wb_valid !== ev[i] || o_wb_addr !== ea[i]) begin errors++; $display("FAIL decode_%0d: got %0b/%0d want %0b/%0d", i, o_wb_valid, o_wb_addr, ev[i], ea[i]); end
            @(posedge clk); #1;
        end
        i_rd_addr_a = 5'd6;
        i_rd_addr_b = 5'd10;
        #1;
        checks++; if (o_rd_data_a !== 32'hA4 || o_rd_data_b !== 32'hA5) begin errors++; $display("FAIL decode_regs: got %h/%h want a4/a5", o_rd_data_a, o_rd_data_b); end
        i_rd_addr_a = 5'd4;
        #1;
        checks++; if (o_rd_data_a !== 32'd0) begin errors++; $display("FAIL decode_r4: got %h want 0", o_rd_data_a); end
    endtask

    task automatic test_back_to_back;
        i_rd_addr_a = 5'd3;
        set_in(1'b1, rtype(5'd3, 6'b100101), 32'h11, 3'b000);
        @(posedge clk); #1;
        set_in(1'b1, rtype(5'd3, 6'b100101), 32'h22, 3'b000);
        #1;
        checks++; if (o_wb_data !== 32'h11 || o_rd_data_a !== 32'h11) begin errors++; $display("FAIL b2b_first: got %h/%h want 11/11", o_wb_data, o_rd_data_a); end
        checks++; if (o_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %0b want 1", o_in_ready); end
        @(posedge clk); #1;
        set_in(1'b0, 32'd0, 32'd0, 3'b000);
        #1;
        checks++; if (o_wb_valid !== 1'b1 || o_wb_data !== 32'h22 || o_rd_data_a !== 32'h22) begin errors++; $display("FAIL b2b_second: got %0b/%h/%h want 1/22/22", o_wb_valid, o_wb_data, o_rd_data_a); end
        @(posedge clk); #1;
        checks++; if (o_wb_valid !== 1'b0 || o_rd_data_a !== 32'h22) begin errors++; $display("FAIL b2b_final: got %0b/%h want 0/22", o_wb_valid, o_rd_data_a); end
    endtask

    task automatic test_branch;
        set_in(1'b1, itype(6'b000100, 5'd1), 32'h0000_0010, 3'b000);
        @(posedge clk); #1;
        set_in(1'b0, 32'd0, 32'd0, 3'b000);
        #1;
        checks++; if (o_br_taken !== 1'b1 || o_br_offset !== 16'h0010) begin errors++; $display("FAIL beq_taken: got %0b/%h want 1/0010", o_br_taken, o_br_offset); end
        checks++; if (o_wb_valid !== 1'b0) begin errors++; $display("FAIL beq_wbv: got %0b want 0", o_wb_valid); end
        @(posedge clk); #1;
        checks++; if (o_br_taken !== 1'b0 || o_br_offset !== 16'h0010) begin errors++; $display("FAIL beq_hold: got %0b/%h want 0/0010", o_br_taken, o_br_offset); end
        set_in(1'b1, itype(6'b000101, 5'd1), 32'h0000_0020, 3'b001);
        @(posedge clk); #1;
        set_in(1'b0, 32'd0, 32'd0, 3'b000);
        #1;
        checks++; if (o_br_taken !== 1'b0 || o_br_offset !== 16'h0020) begin errors++; $display("FAIL bne_not_taken: got %0b/%h want 0/0020", o_br_taken, o_br_offset); end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow;
        checks++; if (o_ovf_count !== 16'd0 || o_sticky_flags !== 3'b000) begin errors++; $display("FAIL ovf_start: got %h/%b want 0/000", o_ovf_count, o_sticky_flags); end
        set_in(1'b1, rtype(5'd7, 6'b100000), 32'h8000_0000, 3'b100);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (o_ovf_count !== 16'd1 || o_sticky_flags !== 3'b100) begin errors++; $display("FAIL ovf_one: got %h/%b want 1/100", o_ovf_count, o_sticky_flags); end
        @(posedge clk); #1;
        set_in(1'b0, 32'd0, 32'd0, 3'b000);
        checks++; if (o_ovf_count !== 16'd2) begin errors++; $display("FAIL ovf_two: got %h want 2", o_ovf_count); end
        i_sticky_clr = 1'b1;
        @(posedge clk); #1;
        i_sticky_clr = 1'b0;
        checks++; if (o_ovf_count !== 16'd1 || o_sticky_flags !== 3'b100) begin errors++; $display("FAIL ovf_clr_upd: got %h/%b want 1/100", o_ovf_count, o_sticky_flags); end
        set_in(1'b1, rtype(5'd7, 6'b100000), 32'h8000_0000, 3'b110);
        repeat (65540) @(posedge clk);
        #1;
        set_in(1'b0, 32'd0, 32'd0, 3'b000);
        @(posedge clk); #1;
        checks++; if (o_ovf_count !== 16'hFFFF || o_sticky_flags !== 3'b110) begin errors++; $display("FAIL ovf_sat: got %h/%b want ffff/110", o_ovf_count, o_sticky_flags); end
        set_in(1'b1, itype(6'b001000, 5'd7), 32'h8000_0000, 3'b100);
        @(posedge clk); #1;
        set_in(1'b0, 32'd0, 32'd0, 3'b000);
        @(posedge clk); #1;
        checks++; if (o_ovf_count !== 16'hFFFF) begin errors++; $display("FAIL ovf_sat_hold: got %h want ffff", o_ovf_count); end
        i_sticky_clr = 1'b1;
        @(posedge clk); #1;
        i_sticky_clr = 1'b0;
        checks++; if (o_ovf_count !== 16'd0 || o_sticky_flags !== 3'b000) begin errors++; $display("FAIL ovf_clr: got %h/%b want 0/000", o_ovf_count, o_sticky_flags); end
    endtask

`ifdef ALU_WB_OVF_TRAP_EN
    task automatic test_trap;
        i_rd_addr_a = 5'd5;
        set_in(1'b1, rtype(5'd5, 6'b100101), 32'h1234, 3'b000);
        @(posedge clk); #1;
        set_in(1'b0, 32'd0, 32'd0, 3'b000);
        @(posedge clk); #1;
        checks++; if (o_rd_data_a !== 32'h1234) begin errors++; $display("FAIL trap_pre_r5: got %h want 1234", o_rd_data_a); end
        set_in(1'b1, rtype(5'd5, 6'b100010), 32'h0BAD, 3'b100);
        @(posedge clk); #1;
        set_in(1'b0, 32'd0, 32'd0, 3'b000);
        #1;
        checks++; if (o_wb_valid !== 1'b0 || o_trap !== 1'b0 || o_rd_data_a !== 32'h1234) begin errors++; $display("FAIL trap_commit: got %0b/%0b/%h want 0/0/1234", o_wb_valid, o_trap, o_rd_data_a); end
        @(posedge clk); #1;
        checks++; if (o_trap !== 1'b1 || o_in_ready !== 1'b0) begin errors++; $display("FAIL trap_set: got %0b/%0b want 1/0", o_trap, o_in_ready); end
        checks++; if (o_rd_data_a !== 32'h1234 || o_ovf_count !== 16'd1 || o_sticky_flags[2] !== 1'b1) begin errors++; $display("FAIL trap_state: got %h/%h/%b want 1234/1/1xx", o_rd_data_a, o_ovf_count, o_sticky_flags); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (o_trap !== 1'b1 || o_in_ready !== 1'b0) begin errors++; $display("FAIL trap_hold: got %0b/%0b want 1/0", o_trap, o_in_ready); end
        i_trap_ack = 1'b1;
        @(posedge clk); #1;
        i_trap_ack = 1'b0;
        checks++; if (o_trap !== 1'b0 || o_in_ready !== 1'b1) begin errors++; $display("FAIL trap_ack: got %0b/%0b want 0/1", o_trap, o_in_ready); end
        i_trap_ack = 1'b1;
        @(posedge clk); #1;
        i_trap_ack = 1'b0;
        checks++; if (o_trap !== 1'b0 || o_in_ready !== 1'b1) begin errors++; $display("FAIL trap_stray_ack: got %0b/%0b want 0/1", o_trap, o_in_ready); end
    endtask
`endif

    task automatic test_reset_midstream;
        set_in(1'b1, rtype(5'd9, 6'b100000), 32'hDEAD, 3'b000);
        @(posedge clk); #1;
        set_in(1'b0, 32'd0, 32'd0, 3'b000);
        rst_n = 1'b0;
        #1;
        checks++; if (o_wb_valid !== 1'b0 || o_br_offset !== 16'd0) begin errors++; $display("FAIL mid_reset_out: got %0b/%h want 0/0", o_wb_valid, o_br_offset); end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        i_rd_addr_a = 5'd9;
        i_rd_addr_b = 5'd2;
        #1;
        checks++; if (o_rd_data_a !== 32'd0 || o_rd_data_b !== 32'd0) begin errors++; $display("FAIL mid_reset_regs: got %h/%h want 0/0", o_rd_data_a, o_rd_data_b); end
        i_rd_addr_a = 5'd3;
        i_rd_addr_b = 5'd6;
        #1;
        checks++; if (o_rd_data_a !== 32'd0 || o_rd_data_b !== 32'd0) begin errors++; $display("FAIL mid_reset_regs2: got %h/%h want 0/0", o_rd_data_a, o_rd_data_b); end
        checks++; if (o_in_ready !== 1'b1 || o_sticky_flags !== 3'd0 || o_ovf_count !== 16'd0) begin errors++; $display("FAIL mid_reset_stat: got %0b/%b/%h want 1/000/0", o_in_ready, o_sticky_flags, o_ovf_count); end
    endtask

    initial begin
        rst_n        = 1'b0;
        i_sticky_clr = 1'b0;
        i_rd_addr_a  = 5'd0;
        i_rd_addr_b  = 5'd0;
`ifdef ALU_WB_OVF_TRAP_EN
        i_trap_ack   = 1'b0;
`endif
        set_in(1'b0, 32'd0, 32'd0, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset;
        test_write_bypass;
        test_reg0;
        test_decode;
        test_back_to_back;
        test_branch;
`ifdef ALU_WB_OVF_TRAP_EN
        test_trap;
`else
        test_overflow;
`endif
        test_reset_midstream;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
